// File: rtl/alu_decode_unit.sv
// alu_decode_unit: 8-bit ALU with registered zero/carry flags, plus a
// combinational x/y/z opcode field splitter for the Z80-style core.
module alu_decode_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  input  logic [2:0] operator,
  output logic [7:0] result,
  output logic       flag_zero,
  output logic       flag_carry,
  input  logic [7:0] insn,
  output logic [1:0] insn_x,
  output logic [2:0] insn_y,
  output logic [2:0] insn_z
);

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  alu_op_e    op;
  logic [8:0] sum;
  logic [8:0] diff;
  logic       carry_next;
  logic       zero_next;

  assign op = alu_op_e'(operator);

  // 9-bit add/subtract so bit 8 carries the carry-out or the borrow.
  assign sum  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff = {1'b0, operand_a} - {1'b0, operand_b};

  // Result and candidate carry for the selected operation.
  always_comb begin
    result     = operand_a;
    carry_next = 1'b0;
    unique case (op)
      ALU_NOP: begin
        result     = operand_a;
        carry_next = flag_carry;
      end
      ALU_ADD: begin
        result     = sum[7:0];
        carry_next = sum[8];
      end
      ALU_SUB: begin
        result     = diff[7:0];
        carry_next = diff[8];
      end
      ALU_AND: result = operand_a & operand_b;
      ALU_OR:  result = operand_a | operand_b;
      ALU_XOR: result = operand_a ^ operand_b;
      ALU_SHL: begin
        result     = {operand_a[6:0], 1'b0};
        carry_next = operand_a[7];
      end
      ALU_SHR: begin
        result     = {1'b0, operand_a[7:1]};
        carry_next = operand_a[0];
      end
      default: begin
        result     = operand_a;
        carry_next = flag_carry;
      end
    endcase
  end

  assign zero_next = (result == '0);

  // Flag registers: load on any non-NOP operation, hold on NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else if (op != ALU_NOP) begin
      flag_zero  <= zero_next;
      flag_carry <= carry_next;
    end
  end

  // Opcode field split: every opcode decodes, no state involved.
  assign insn_x = insn[7:6];
  assign insn_y = insn[5:3];
  assign insn_z = insn[2:0];

endmodule

// File: tb/tb_alu_decode_unit.sv
// Directed self-checking bench for alu_decode_unit.
module tb_alu_decode_unit;

  logic       clk;
  logic       rst;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [2:0] operator;
  logic [7:0] result;
  logic       flag_zero;
  logic       flag_carry;
  logic [7:0] insn;
  logic [1:0] insn_x;
  logic [2:0] insn_y;
  logic [2:0] insn_z;

  int unsigned pass_count = 0;
  int unsigned total_count = 0;

  localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                         OP_OR  = 3'd4, OP_XOR = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7;

  alu_decode_unit dut (
    .clk(clk), .rst(rst),
    .operand_a(operand_a), .operand_b(operand_b), .operator(operator),
    .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .insn(insn), .insn_x(insn_x), .insn_y(insn_y), .insn_z(insn_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a new operation mid-cycle (after the falling edge).
  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    operator  = op;
    operand_a = a;
    operand_b = b;
    #1;
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total_count++;
    if (flag_zero !== 1'b0) $display("FAIL reset_zero got=%b exp=0", flag_zero);
    else pass_count++;
    total_count++;
    if (flag_carry !== 1'b0) $display("FAIL reset_carry got=%b exp=0", flag_carry);
    else pass_count++;
  endtask

  task automatic test_add_wrap();
    drive(OP_ADD, 8'hFF, 8'h01);
    total_count++;
    if (result !== 8'h00) $display("FAIL add_wrap_result got=%h exp=00", result);
    else pass_count++;
    tick();
    total_count++;
    if (flag_zero !== 1'b1) $display("FAIL add_wrap_zero got=%b exp=1", flag_zero);
    else pass_count++;
    total_count++;
    if (flag_carry !== 1'b1) $display("FAIL add_wrap_carry got=%b exp=1", flag_carry);
    else pass_count++;
  endtask

  task automatic test_sub_borrow();
    drive(OP_SUB, 8'h05, 8'h07);
    total_count++;
    if (result !== 8'hFE) $display("FAIL sub_borrow_result got=%h exp=fe", result);
    else pass_count++;
    tick();
    total_count++;
    if (flag_zero !== 1'b0) $display("FAIL sub_borrow_zero got=%b exp=0", flag_zero);
    else pass_count++;
    total_count++;
    if (flag_carry !== 1'b1) $display("FAIL sub_borrow_carry got=%b exp=1", flag_carry);
    else pass_count++;

    drive(OP_SUB, 8'h07, 8'h07);
    total_count++;
    if (result !== 8'h00) $display("FAIL sub_equal_result got=%h exp=00", result);
    else pass_count++;
    tick();
    total_count++;
    if (flag_zero !== 1'b1) $display("FAIL sub_equal_zero got=%b exp=1", flag_zero);
    else pass_count++;
    total_count++;
    if (flag_carry !== 1'b0) $display("FAIL sub_equal_carry got=%b exp=0", flag_carry);
    else pass_count++;
  endtask

  task automatic test_logic_shift();
    // Table: op, a, b, expected result, zero, carry.
    logic [2:0] ops  [6] = '{OP_AND, OP_XOR, OP_SHL, OP_SHR, OP_OR,  OP_ADD};
    logic [7:0] as   [6] = '{8'hF0,  8'hAA,  8'h81,  8'h01,  8'h0C,  8'h3C};
    logic [7:0] bs   [6] = '{8'h0F,  8'hFF,  8'hFF,  8'hFF,  8'h30,  8'h05};
    logic [7:0] exps [6] = '{8'h00,  8'h55,  8'h02,  8'h00,  8'h3C,  8'h41};
    logic       expz [6] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
    logic       expc [6] = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};
    // Preload carry so that logic ops visibly clear it.
    drive(OP_ADD, 8'h80, 8'h81);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], as[i], bs[i]);
      total_count++;
      if (result !== exps[i]) $display("FAIL logic_result[%0d] got=%h exp=%h", i, result, exps[i]);
      else pass_count++;
      tick();
      total_count++;
      if (flag_zero !== expz[i]) $display("FAIL logic_zero[%0d] got=%b exp=%b", i, flag_zero, expz[i]);
      else pass_count++;
      total_count++;
      if (flag_carry !== expc[i]) $display("FAIL logic_carry[%0d] got=%b exp=%b", i, flag_carry, expc[i]);
      else pass_count++;
    end
  endtask

  task automatic test_nop_hold();
    drive(OP_ADD, 8'h80, 8'h80);
    total_count++;
    if (result !== 8'h00) $display("FAIL nop_setup_result got=%h exp=00", result);
    else pass_count++;
    tick();
    drive(OP_NOP, 8'h00, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      total_count++;
      if (result !== 8'h00) $display("FAIL nop_result[%0d] got=%h exp=00", i, result);
      else pass_count++;
      tick();
      total_count++;
      if (flag_zero !== 1'b1) $display("FAIL nop_zero[%0d] got=%b exp=1", i, flag_zero);
      else pass_count++;
      total_count++;
      if (flag_carry !== 1'b1) $display("FAIL nop_carry[%0d] got=%b exp=1", i, flag_carry);
      else pass_count++;
    end
    // NOP with a nonzero operand: result follows a, flags still hold.
    drive(OP_NOP, 8'h37, 8'h00);
    total_count++;
    if (result !== 8'h37) $display("FAIL nop_pass_result got=%h exp=37", result);
    else pass_count++;
    tick();
    total_count++;
    if ({flag_zero, flag_carry} !== 2'b11) $display("FAIL nop_pass_flags got=%b exp=11", {flag_zero, flag_carry});
    else pass_count++;
  endtask

  task automatic test_reset_async();
    // Flags are 1/1 from the NOP test; load a pending ADD then reset mid-cycle.
    drive(OP_ADD, 8'hFF, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    total_count++;
    if ({flag_zero, flag_carry} !== 2'b00) $display("FAIL async_reset_flags got=%b exp=00", {flag_zero, flag_carry});
    else pass_count++;
    total_count++;
    if (result !== 8'h00) $display("FAIL reset_result_tracks got=%h exp=00", result);
    else pass_count++;
    tick();
    total_count++;
    if ({flag_zero, flag_carry} !== 2'b00) $display("FAIL reset_discard got=%b exp=00", {flag_zero, flag_carry});
    else pass_count++;
    @(negedge clk);
    rst = 1'b0;
    drive(OP_SUB, 8'h05, 8'h07);
    tick();
    total_count++;
    if ({flag_zero, flag_carry} !== 2'b01) $display("FAIL post_reset_flags got=%b exp=01", {flag_zero, flag_carry});
    else pass_count++;
  endtask

  task automatic test_decoder();
    logic [7:0] codes [6] = '{8'h3E, 8'h04, 8'hC3, 8'h00, 8'hFF, 8'h76};
    logic [1:0] ex    [6] = '{2'd0,  2'd0,  2'd3,  2'd0,  2'd3,  2'd1};
    logic [2:0] ey    [6] = '{3'd7,  3'd0,  3'd0,  3'd0,  3'd7,  3'd6};
    logic [2:0] ez    [6] = '{3'd6,  3'd4,  3'd3,  3'd0,  3'd7,  3'd6};
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      insn = codes[i];
      #1;
      total_count++;
      if (insn_x !== ex[i]) $display("FAIL dec_x[%h] got=%0d exp=%0d", codes[i], insn_x, ex[i]);
      else pass_count++;
      total_count++;
      if (insn_y !== ey[i]) $display("FAIL dec_y[%h] got=%0d exp=%0d", codes[i], insn_y, ey[i]);
      else pass_count++;
      total_count++;
      if (insn_z !== ez[i]) $display("FAIL dec_z[%h] got=%0d exp=%0d", codes[i], insn_z, ez[i]);
      else pass_count++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    operand_a = 8'h00;
    operand_b = 8'h00;
    operator  = OP_NOP;
    insn      = 8'h00;
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_add_wrap();
    test_sub_borrow();
    test_logic_shift();
    test_nop_hold();
    test_reset_async();
    test_decoder();
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass_count, total_count);
    $fatal(1, "timeout");
  end

endmodule
